mdu_ctrl: RTL

//  Multiply/divide unit controller sitting beside the execute stage. Accepts MDU ops issued from EX,

---
 rtl/mdu_ctrl_pkg.sv | 36 +++
 rtl/mdu_div_iter.sv | 83 ++++++++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - MDU op one-hot indices, divider FSM states, multiply-pipe kinds.
package mdu_ctrl_pkg;

  localparam int MDOP_W    = 12;
  localparam int DIV_ITERS = 32;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;
  localparam int OP_MFHI  = 6;
  localparam int OP_MFLO  = 7;
  localparam int OP_MADD  = 8;
  localparam int OP_MADDU = 9;
  localparam int OP_MSUB  = 10;
  localparam int OP_MSUBU = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    MK_PLAIN = 2'd0,
    MK_ADD   = 2'd1,
    MK_SUB   = 2'd2
  } mul_kind_e;

  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring-divide datapath: one quotient bit per cycle over unsigned operands.
module mdu_div_iter
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        cancel_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;

  logic [32:0] rem_shift;
  logic [32:0] trial;

  // Partial remainder is always below the divisor, so the shifted value fits in 33 bits.
  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dsr_q};

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    if (cancel_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 5'd0;
      rem_d  = 32'd0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_ITERS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 5'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dsr_q  <= 32'd0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU controller: 2-stage multiply pipe, divider FSM, HI/LO ownership.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU in the multiply pipe.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mdu_start_i,
  input  logic [MDOP_W-1:0] mdu_op_i,
  input  logic [31:0]       mdu_opr1_i,
  input  logic [31:0]       mdu_opr2_i,
  input  logic              mdu_cancel_i,
  output logic              mdu_is_active,
  output logic              mdu_div_active,
  output logic              mdu_stallreq_o,
  output logic [31:0]       mdu_hi_o,
  output logic [31:0]       mdu_lo_o
);

  div_state_e  state_q, state_d;
  mul_kind_e   kind_q, kind_d, issue_kind;
  logic        mul_v_q, mul_v_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, div0_q, div0_d;
  logic [31:0] dvd_raw_q, dvd_raw_d;

  logic        issue, mul_issue, div_start, div_signed;
  logic        macc_op, macc_signed, mul_signed;
  logic [63:0] a_ext, b_ext, sum64;
  logic        iter_done;
  logic [31:0] iter_quo, iter_rem, quo_fix, rem_fix;

`ifdef MDU_MADD_EN
  assign macc_op     = mdu_op_i[OP_MADD] | mdu_op_i[OP_MADDU] | mdu_op_i[OP_MSUB] | mdu_op_i[OP_MSUBU];
  assign macc_signed = mdu_op_i[OP_MADD] | mdu_op_i[OP_MSUB];
  assign issue_kind  = (mdu_op_i[OP_MSUB] | mdu_op_i[OP_MSUBU]) ? MK_SUB :
                       (mdu_op_i[OP_MADD] | mdu_op_i[OP_MADDU]) ? MK_ADD : MK_PLAIN;
`else
  logic unused_macc_ops;
  assign unused_macc_ops = ^mdu_op_i[OP_MSUBU:OP_MADD];
  assign macc_op         = 1'b0;
  assign macc_signed     = 1'b0;
  assign issue_kind      = MK_PLAIN;
`endif

  assign mdu_is_active  = mul_v_q | (state_q != S_IDLE);
  assign mdu_div_active = (state_q == S_DIV) | (state_q == S_FIX);
  assign mdu_stallreq_o = mdu_start_i & mdu_is_active &
                          (mdu_op_i[OP_MTHI] | mdu_op_i[OP_MTLO] | mdu_op_i[OP_MFHI] | mdu_op_i[OP_MFLO]);

  assign issue      = mdu_start_i & ~mdu_stallreq_o & ~mdu_cancel_i;
  assign mul_issue  = issue & (mdu_op_i[OP_MULT] | mdu_op_i[OP_MULTU] | macc_op);
  assign mul_signed = mdu_op_i[OP_MULT] | macc_signed;
  assign div_signed = mdu_op_i[OP_DIV];
  assign div_start  = issue & (mdu_op_i[OP_DIV] | mdu_op_i[OP_DIVU]) & (state_q == S_IDLE);

  // The low 64 bits of a 64x64 product of sign/zero-extended operands give both signed and unsigned results.
  assign a_ext = {{32{mul_signed & mdu_opr1_i[31]}}, mdu_opr1_i};
  assign b_ext = {{32{mul_signed & mdu_opr2_i[31]}}, mdu_opr2_i};

  mdu_div_iter u_div_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .cancel_i   (mdu_cancel_i),
    .dividend_i (abs_val(mdu_opr1_i, div_signed)),
    .divisor_i  (abs_val(mdu_opr2_i, div_signed)),
    .done_o     (iter_done),
    .quo_o      (iter_quo),
    .rem_o      (iter_rem)
  );

  assign quo_fix = neg_q_q ? (~iter_quo + 32'd1) : iter_quo;
  assign rem_fix = neg_r_q ? (~iter_rem + 32'd1) : iter_rem;

  always_comb begin
    case (kind_q)
      MK_ADD:  sum64 = {hi_q, lo_q} + prod_q;
      MK_SUB:  sum64 = {hi_q, lo_q} - prod_q;
      default: sum64 = prod_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_v_d   = mul_issue;
    prod_d    = prod_q;
    kind_d    = kind_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    div0_d    = div0_q;
    dvd_raw_d = dvd_raw_q;

    if (mul_issue) begin
      prod_d = a_ext * b_ext;
      kind_d = issue_kind;
    end

    if (mul_v_q && !mdu_cancel_i) begin
      {hi_d, lo_d} = sum64;
    end

    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          state_d   = S_DIV;
          neg_q_d   = div_signed & (mdu_opr1_i[31] ^ mdu_opr2_i[31]);
          neg_r_d   = div_signed & mdu_opr1_i[31];
          div0_d    = (mdu_opr2_i == 32'd0);
          dvd_raw_d = mdu_opr1_i;
        end
      end
      S_DIV: begin
        if (mdu_cancel_i)   state_d = S_IDLE;
        else if (iter_done) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!mdu_cancel_i) begin
          if (div0_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = dvd_raw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue && mdu_op_i[OP_MTHI]) hi_d = mdu_opr1_i;
    if (issue && mdu_op_i[OP_MTLO]) lo_d = mdu_opr1_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mul_v_q   <= 1'b0;
      prod_q    <= 64'd0;
      kind_q    <= MK_PLAIN;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      div0_q    <= 1'b0;
      dvd_raw_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      mul_v_q   <= mul_v_d;
      prod_q    <= prod_d;
      kind_q    <= kind_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      div0_q    <= div0_d;
      dvd_raw_q <= dvd_raw_d;
    end
  end

  assign mdu_hi_o = hi_q;
  assign mdu_lo_o = lo_q;

endmodule
